matrix_mac_engine: RTL and testbench

- Parametrised N×N matrix multiplier; the successor to the fixed 4×4, 16-bit tristate-bus multiplier.
- Operands load over a valid/ready port, one full matrix per beat, with A/B selected per beat.
- The product is computed by a single time-multiplexed MAC (one multiply-accumulate per cycle) and returned over a valid/ready result port.
- Adds signed/unsigned mode, optional saturation, an overflow flag and backpressure. Sits behind the ALU bus decoder; no tristate.

---
 rtl/matrix_mac_engine.sv | 199 +++++++++++++++++++
 tb/tb_matrix_mac_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine
//   Parametrised N x N matrix multiplier built around a single time-multiplexed
//   multiply-accumulate unit. Operand matrices arrive one whole matrix per beat.
//   The product C = A * B is produced one MAC per cycle, so a job takes N^3 cycles.
//   The result is then held on a valid/ready port until the consumer takes it.
//
// Ports
//   clk           rising-edge clock
//   reset_l       asynchronous active-low reset
//   load_valid    load beat present
//   load_ready    high only while idle
//   load_sel      0 = write matrix A, 1 = write matrix B
//   load_data     N*N*DW row-major matrix; element (r,c) at [(r*N+c)*DW +: DW]
//   start         begin a job (honoured only while idle and not loading)
//   signed_mode   sampled with start; 1 = two's-complement operands
//   busy          job in progress or result waiting
//   done          single-cycle pulse on the first cycle of result_valid
//   result_valid  result available
//   result_ready  consumer accepts the result
//   result_data   C matrix, same packing as load_data
//   overflow      some element of the result left the DW range
module matrix_mac_engine #(
    parameter int N        = 4,
    parameter int DW       = 16,
    parameter int ACCW     = 2*DW + 4,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              load_sel,
    input  logic [N*N*DW-1:0] load_data,
    input  logic              start,
    input  logic              signed_mode,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [N*N*DW-1:0] result_data,
    output logic              overflow
);

    localparam int CW = $clog2(N);
    localparam int MW = N*N*DW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   c_cnt;
    logic [CW-1:0]   k_cnt;
    logic [MW-1:0]   a_mem;
    logic [MW-1:0]   b_mem;
    logic [MW-1:0]   c_mem;
    logic [ACCW-1:0] acc;
    logic            mode_signed;
    logic            ovf_sticky;

    logic [DW-1:0]          a_el;
    logic [DW-1:0]          b_el;
    logic signed [2*DW-1:0] prod_s;
    logic [2*DW-1:0]        prod_u;
    logic [ACCW-1:0]        prod_ext;
    logic [ACCW-1:0]        sum;
    logic [DW:0]            conv;
    logic                   last_k;
    logic                   last_elem;

    // Range-check and narrow one accumulated sum. Bit DW of the return value is
    // the out-of-range flag, and the low DW bits are the stored element. A value
    // is in range when every bit above the kept field is a copy of the kept
    // field's top bit (signed) or zero (unsigned).
    function automatic logic [DW:0] convert(input logic [ACCW-1:0] v, input logic sgn);
        logic          in_range;
        logic [DW-1:0] clamped;
        if (sgn) begin
            in_range = (v[ACCW-1:DW-1] == {(ACCW-DW+1){1'b0}}) ||
                       (v[ACCW-1:DW-1] == {(ACCW-DW+1){1'b1}});
            clamped  = v[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            in_range = (v[ACCW-1:DW] == {(ACCW-DW){1'b0}});
            clamped  = {DW{1'b1}};
        end
        convert = {~in_range, ((SATURATE != 0) && !in_range) ? clamped : v[DW-1:0]};
    endfunction

    assign a_el     = a_mem[(int'(r_cnt)*N + int'(k_cnt))*DW +: DW];
    assign b_el     = b_mem[(int'(k_cnt)*N + int'(c_cnt))*DW +: DW];
    assign prod_s   = $signed(a_el) * $signed(b_el);
    assign prod_u   = a_el * b_el;
    assign prod_ext = mode_signed ? {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s}
                                  : {{(ACCW-2*DW){1'b0}}, prod_u};
    assign sum       = acc + prod_ext;
    assign conv      = convert(sum, mode_signed);
    assign last_k    = (k_cnt == CW'(N-1));
    assign last_elem = last_k && (c_cnt == CW'(N-1)) && (r_cnt == CW'(N-1));

    assign result_data = c_mem;
    assign overflow    = ovf_sticky;

    // Next-state selection; a load beat takes priority over start in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && !load_valid) next_state = COMPUTE;
                else                      next_state = IDLE;
            end
            COMPUTE: begin
                if (last_elem) next_state = HOLD;
                else           next_state = COMPUTE;
            end
            HOLD: begin
                if (result_valid && result_ready) next_state = IDLE;
                else                              next_state = HOLD;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) state <= IDLE;
        else          state <= next_state;
    end

    // Operand/result storage, loop counters and the accumulator.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            a_mem       <= {MW{1'b0}};
            b_mem       <= {MW{1'b0}};
            c_mem       <= {MW{1'b0}};
            acc         <= {ACCW{1'b0}};
            r_cnt       <= {CW{1'b0}};
            c_cnt       <= {CW{1'b0}};
            k_cnt       <= {CW{1'b0}};
            mode_signed <= 1'b0;
            ovf_sticky  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        if (load_sel) b_mem <= load_data;
                        else          a_mem <= load_data;
                    end else if (start && !load_valid) begin
                        mode_signed <= signed_mode;
                        ovf_sticky  <= 1'b0;
                        acc         <= {ACCW{1'b0}};
                        r_cnt       <= {CW{1'b0}};
                        c_cnt       <= {CW{1'b0}};
                        k_cnt       <= {CW{1'b0}};
                    end
                end
                COMPUTE: begin
                    if (last_k) begin
                        c_mem[(int'(r_cnt)*N + int'(c_cnt))*DW +: DW] <= conv[DW-1:0];
                        ovf_sticky <= ovf_sticky | conv[DW];
                        acc        <= {ACCW{1'b0}};
                        k_cnt      <= {CW{1'b0}};
                        if (c_cnt == CW'(N-1)) begin
                            c_cnt <= {CW{1'b0}};
                            r_cnt <= (r_cnt == CW'(N-1)) ? {CW{1'b0}} : r_cnt + CW'(1);
                        end else begin
                            c_cnt <= c_cnt + CW'(1);
                        end
                    end else begin
                        acc   <= sum;
                        k_cnt <= k_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered handshake/status outputs. result_valid rises one cycle after
    // entering HOLD, and done marks exactly that first valid cycle.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            load_ready   <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            load_ready   <= (next_state == IDLE);
            busy         <= (next_state != IDLE);
            result_valid <= (state == HOLD) && !(result_valid && result_ready);
            done         <= (state == HOLD) && !result_valid;
        end
    end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Bench for matrix_mac_engine (N=4, DW=16). It runs two instances in lockstep:
// one truncating and one saturating. A reference model computes C = A*B with
// plain integer arithmetic. It is checked against both results on every cycle
// where result_valid is high. Literal expectations pin the model and timing.
module tb_matrix_mac_engine;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int W  = N*N*DW;

    logic         clk = 1'b0;
    logic         reset_l;
    logic         load_valid, load_sel, start, signed_mode, result_ready;
    logic [W-1:0] load_data;

    logic         load_ready, busy, done, result_valid, overflow;
    logic [W-1:0] result_data;
    logic         s_load_ready, s_busy, s_done, s_result_valid, s_overflow;
    logic [W-1:0] s_result_data;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;

    logic [15:0] ma [16];
    logic [15:0] mb [16];
    logic [15:0] e_trunc [16];
    logic [15:0] e_sat [16];
    logic        e_ovf;

    always #5 clk = ~clk;

    matrix_mac_engine #(.N(N), .DW(DW), .SATURATE(0)) dut (
        .clk(clk), .reset_l(reset_l), .load_valid(load_valid), .load_ready(load_ready),
        .load_sel(load_sel), .load_data(load_data), .start(start), .signed_mode(signed_mode),
        .busy(busy), .done(done), .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .overflow(overflow)
    );

    matrix_mac_engine #(.N(N), .DW(DW), .SATURATE(1)) dut_sat (
        .clk(clk), .reset_l(reset_l), .load_valid(load_valid), .load_ready(s_load_ready),
        .load_sel(load_sel), .load_data(load_data), .start(start), .signed_mode(signed_mode),
        .busy(s_busy), .done(s_done), .result_valid(s_result_valid), .result_ready(result_ready),
        .result_data(s_result_data), .overflow(s_overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Reference product: plain integer sums followed by range classification.
    task automatic model(input logic sm);
        longint s, av, bv, lo, hi;
        e_ovf = 1'b0;
        lo = sm ? -64'sd32768 : 64'sd0;
        hi = sm ? 64'sd32767  : 64'sd65535;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int k = 0; k < N; k++) begin
                    av = sm ? longint'($signed(ma[r*N+k])) : longint'(ma[r*N+k]);
                    bv = sm ? longint'($signed(mb[k*N+c])) : longint'(mb[k*N+c]);
                    s += av * bv;
                end
                e_trunc[r*N+c] = s[15:0];
                if (s > hi) begin
                    e_ovf = 1'b1;
                    e_sat[r*N+c] = hi[15:0];
                end else if (s < lo) begin
                    e_ovf = 1'b1;
                    e_sat[r*N+c] = lo[15:0];
                end else begin
                    e_sat[r*N+c] = s[15:0];
                end
            end
        end
    endtask

    function automatic logic [W-1:0] pack(input logic sel);
        logic [W-1:0] p;
        for (int i = 0; i < N*N; i++) p[i*DW +: DW] = sel ? mb[i] : ma[i];
        return p;
    endfunction

    // Every cycle a result is presented, both instances must match the model.
    always @(negedge clk) begin
        if (reset_l && result_valid) begin
            for (int i = 0; i < N*N; i++)
                chk($sformatf("trunc_c[%0d]", i), result_data[i*DW +: DW], e_trunc[i]);
            chk("trunc_ovf", overflow, e_ovf);
        end
        if (reset_l && s_result_valid) begin
            for (int i = 0; i < N*N; i++)
                chk($sformatf("sat_c[%0d]", i), s_result_data[i*DW +: DW], e_sat[i]);
            chk("sat_ovf", s_overflow, e_ovf);
        end
        if (done) done_cnt++;
    end

    task automatic load(input logic sel);
        load_valid = 1'b1;
        load_sel   = sel;
        load_data  = pack(sel);
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    // Run one job; optionally stall the result for 10 cycles while pulsing start/load.
    task automatic run_job(input logic sm, input logic bp);
        int cnt;
        int dc0;
        model(sm);
        dc0 = done_cnt;
        start = 1'b1;
        signed_mode = sm;
        @(posedge clk); #1;
        start = 1'b0;
        signed_mode = 1'b0;
        chk("busy_in_compute", busy, 1'b1);
        chk("load_ready_in_compute", load_ready, 1'b0);
        cnt = 0;
        while (!result_valid && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, 65);
        chk("done_first_valid", done, 1'b1);
        chk("sat_valid", s_result_valid, 1'b1);
        if (bp) begin
            for (int i = 0; i < 10; i++) begin
                start = 1'b1; load_valid = 1'b1; load_sel = 1'b0; load_data = '0;
                @(posedge clk); #1;
                chk("bp_load_ready", load_ready, 1'b0);
                chk("bp_valid_held", result_valid, 1'b1);
                chk("bp_done_low", done, 1'b0);
            end
            start = 1'b0; load_valid = 1'b0;
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk("valid_dropped", result_valid, 1'b0);
        chk("idle_load_ready", load_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("done_pulses", done_cnt - dc0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_l = 1'b1; load_valid = 1'b0; load_sel = 1'b0; load_data = '0;
        start = 1'b0; signed_mode = 1'b0; result_ready = 1'b0;
        #1 reset_l = 1'b0;
        #2;
        chk("rst_load_ready", load_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_data", result_data[63:0], 64'd0);
        chk("rst_ovf", overflow, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_l = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_load_ready", load_ready, 1'b1);

        // Identity times ramp.
        for (int i = 0; i < 16; i++) begin
            ma[i] = (i / 4 == i % 4) ? 16'd1 : 16'd0;
            mb[i] = 16'(i);
        end
        load(1'b0); load(1'b1);
        run_job(1'b0, 1'b0);
        chk("pin_id_c33", result_data[255:240], 64'd15);
        chk("pin_id_c12", result_data[6*16 +: 16], 64'd6);

        // All 2s times all 3s, rerun (with backpressure) without reloading.
        for (int i = 0; i < 16; i++) begin ma[i] = 16'd2; mb[i] = 16'd3; end
        load(1'b0); load(1'b1);
        run_job(1'b0, 1'b0);
        chk("pin_23_c00", result_data[15:0], 64'h18);
        run_job(1'b0, 1'b1);
        run_job(1'b0, 1'b0);
        chk("pin_23_rerun_c21", result_data[9*16 +: 16], 64'h18);

        // Signed: -1 * identity times ramp.
        for (int i = 0; i < 16; i++) begin
            ma[i] = (i / 4 == i % 4) ? 16'hFFFF : 16'h0000;
            mb[i] = 16'(i);
        end
        load(1'b0); load(1'b1);
        run_job(1'b1, 1'b0);
        chk("pin_neg_c33", result_data[255:240], 64'hFFF1);
        chk("pin_neg_c01", result_data[31:16], 64'hFFFF);

        // Unsigned overflow with all 0xFFFF; then the same operands signed (no overflow).
        for (int i = 0; i < 16; i++) begin ma[i] = 16'hFFFF; mb[i] = 16'hFFFF; end
        load(1'b0); load(1'b1);
        run_job(1'b0, 1'b0);
        chk("pin_ff_trunc", result_data[15:0], 64'h0004);
        chk("pin_ff_sat", s_result_data[15:0], 64'hFFFF);
        chk("pin_ff_model_ovf", e_ovf, 1'b1);
        run_job(1'b1, 1'b0);
        chk("pin_ff_signed", s_result_data[15:0], 64'h0004);

        // Signed positive and negative saturation.
        for (int i = 0; i < 16; i++) begin ma[i] = 16'h8000; mb[i] = 16'h8000; end
        load(1'b0); load(1'b1);
        run_job(1'b1, 1'b0);
        chk("pin_pos_sat", s_result_data[15:0], 64'h7FFF);
        for (int i = 0; i < 16; i++) mb[i] = 16'h7FFF;
        load(1'b1);
        run_job(1'b1, 1'b0);
        chk("pin_neg_sat", s_result_data[15:0], 64'h8000);

        // Start together with a load beat: the load wins, no job starts.
        for (int i = 0; i < 16; i++) mb[i] = 16'(i);
        start = 1'b1; load_valid = 1'b1; load_sel = 1'b1; load_data = pack(1'b1);
        @(posedge clk); #1;
        start = 1'b0; load_valid = 1'b0;
        chk("start_with_load_busy", busy, 1'b0);
        chk("start_with_load_ready", load_ready, 1'b1);

        // Reset in the middle of a job, then prove A was cleared.
        for (int i = 0; i < 16; i++) ma[i] = (i / 4 == i % 4) ? 16'd1 : 16'd0;
        load(1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) begin @(posedge clk); #1; end
        reset_l = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", result_valid, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_load_ready", load_ready, 1'b0);
        chk("abort_data", result_data[127:64], 64'd0);
        chk("abort_sat_data", s_result_data[63:0], 64'd0);
        chk("abort_ovf", overflow, 1'b0);
        @(posedge clk); #1;
        reset_l = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", load_ready, 1'b1);
        for (int i = 0; i < 16; i++) ma[i] = 16'd0;
        load(1'b1);
        run_job(1'b0, 1'b0);
        chk("pin_cleared_c11", result_data[5*16 +: 16], 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
